lcd_driver: RTL and testbench

Display-side consumer of the 32-entry LCD character RAM. After a power-on wait it runs the HD44780 8-bit init sequence, then endlessly refreshes a 16x2 panel: it reads positions 0..31 through the RAM's registered read port (lcdPosRead/dataRead, same clock) and writes each byte to the panel with correct enable-pulse timing. Sits between the LCD character RAM and the board's LCD pins.

---
 rtl/lcd_driver.sv | 154 +++++++++++++++
 tb/tb_lcd_driver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_driver.sv
// lcd_driver: HD44780 8-bit init, then endless 16x2 refresh from a 32-entry char RAM (LCD_DRIVER_CURSOR_EN: cursor+blink on).
// Per char: 2 fetch + 1 setup + EN_CYCLES + wait cycles; no backpressure, the panel is paced purely by cycle counts.
module lcd_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int BITS_SIZE  = 5,
  parameter int INIT_WAIT  = 750000,
  parameter int EN_CYCLES  = 25,
  parameter int CMD_WAIT   = 2500,
  parameter int CLEAR_WAIT = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [BITS_SIZE-1:0]  lcdPosRead,
  input  logic [DATA_WIDTH-1:0] dataRead,
  output logic [DATA_WIDTH-1:0] lcd_data,
  output logic                  lcd_rs,
  output logic                  lcd_rw,
  output logic                  lcd_en,
  output logic                  lcd_on,
  output logic                  init_done
);

  localparam int HOLD_CMD = EN_CYCLES + CMD_WAIT;
  localparam int HOLD_CLR = EN_CYCLES + CLEAR_WAIT;
  localparam int MAX_A    = (INIT_WAIT > HOLD_CLR) ? INIT_WAIT : HOLD_CLR;
  localparam int MAX_WAIT = (MAX_A > HOLD_CMD) ? MAX_A : HOLD_CMD;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

`ifdef LCD_DRIVER_CURSOR_EN
  localparam logic [7:0] DISP_CTRL = 8'h0F;
`else
  localparam logic [7:0] DISP_CTRL = 8'h0C;
`endif

  typedef enum logic [2:0] {POWER_WAIT, INIT_CMD, LINE_ADDR, FETCH, SEND, HOLD} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt, hold_last;
  logic [1:0]              init_idx, init_idx_nxt;
  logic [BITS_SIZE-1:0]    pos, pos_nxt;
  logic [DATA_WIDTH-1:0]   byte_q, byte_nxt;
  logic                    rs_q, rs_nxt, done_q, done_nxt;

  function automatic logic [DATA_WIDTH-1:0] init_byte(input logic [1:0] idx);
    init_byte = DATA_WIDTH'(8'h38);
    case (idx)
      2'd0: init_byte = DATA_WIDTH'(8'h38);
      2'd1: init_byte = DATA_WIDTH'(DISP_CTRL);
      2'd2: init_byte = DATA_WIDTH'(8'h01);
      2'd3: init_byte = DATA_WIDTH'(8'h06);
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] line_byte(input logic second_line);
    line_byte = second_line ? DATA_WIDTH'(8'hC0) : DATA_WIDTH'(8'h80);
  endfunction

  // Only a clear command earns the long post-enable wait.
  assign hold_last = (!rs_q && byte_q == DATA_WIDTH'(8'h01)) ? CNT_W'(HOLD_CLR - 1)
                                                             : CNT_W'(HOLD_CMD - 1);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + 1'b1;
    init_idx_nxt = init_idx;
    pos_nxt      = pos;
    byte_nxt     = byte_q;
    rs_nxt       = rs_q;
    done_nxt     = done_q;
    lcd_en       = 1'b0;
    case (state)
      POWER_WAIT: begin
        if (cnt == CNT_W'(INIT_WAIT - 1)) begin
          state_nxt    = INIT_CMD;
          cnt_nxt      = '0;
          init_idx_nxt = 2'd0;
          byte_nxt     = init_byte(2'd0);
          rs_nxt       = 1'b0;
        end
      end
      INIT_CMD, LINE_ADDR, SEND: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
      FETCH: begin
        // Address register plus RAM output register: data is ready on the second cycle.
        if (cnt == CNT_W'(1)) begin
          state_nxt = SEND;
          cnt_nxt   = '0;
          byte_nxt  = dataRead;
          rs_nxt    = 1'b1;
        end
      end
      HOLD: begin
        lcd_en = (cnt < CNT_W'(EN_CYCLES));
        if (cnt == hold_last) begin
          cnt_nxt = '0;
          if (!done_q) begin
            if (init_idx == 2'd3) begin
              state_nxt = LINE_ADDR;
              done_nxt  = 1'b1;
              byte_nxt  = line_byte(pos[BITS_SIZE-1]);
              rs_nxt    = 1'b0;
            end else begin
              state_nxt    = INIT_CMD;
              init_idx_nxt = init_idx + 2'd1;
              byte_nxt     = init_byte(init_idx + 2'd1);
            end
          end else if (!rs_q) begin
            state_nxt = FETCH;
          end else begin
            pos_nxt = pos + 1'b1;
            if (pos_nxt[BITS_SIZE-2:0] == '0) begin
              state_nxt = LINE_ADDR;
              byte_nxt  = line_byte(pos_nxt[BITS_SIZE-1]);
              rs_nxt    = 1'b0;
            end else begin
              state_nxt = FETCH;
            end
          end
        end
      end
      default: state_nxt = POWER_WAIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= POWER_WAIT;
      cnt      <= '0;
      init_idx <= '0;
      pos      <= '0;
      byte_q   <= '0;
      rs_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      init_idx <= init_idx_nxt;
      pos      <= pos_nxt;
      byte_q   <= byte_nxt;
      rs_q     <= rs_nxt;
      done_q   <= done_nxt;
    end
  end

  assign lcdPosRead = pos;
  assign lcd_data   = byte_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_on     = 1'b1;
  assign init_done  = done_q;

endmodule

// File: tb/tb_lcd_driver.sv
// Bench for lcd_driver: scoreboard of expected panel bytes built from a behavioural model of the refresh rules.
module tb_lcd_driver;
  localparam int INIT_WAIT  = 20;
  localparam int EN_CYCLES  = 2;
  localparam int CMD_WAIT   = 4;
  localparam int CLEAR_WAIT = 8;
`ifdef LCD_DRIVER_CURSOR_EN
  localparam logic [7:0] DISP_CTRL = 8'h0F;
`else
  localparam logic [7:0] DISP_CTRL = 8'h0C;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] lcdPosRead;
  logic [7:0] dataRead = 8'h00;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on, init_done;

  lcd_driver #(
    .DATA_WIDTH(8), .BITS_SIZE(5), .INIT_WAIT(INIT_WAIT),
    .EN_CYCLES(EN_CYCLES), .CMD_WAIT(CMD_WAIT), .CLEAR_WAIT(CLEAR_WAIT)
  ) dut (
    .clock(clock), .reset(reset), .lcdPosRead(lcdPosRead), .dataRead(dataRead),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_on(lcd_on), .init_done(init_done)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] data; logic rs; int gap; int wt; logic done; int pos; } exp_t;
  typedef struct { int trig; int pos; logic [7:0] val; } wr_t;

  exp_t       exp_q[$];
  wr_t        wr_q[$];
  logic [7:0] ram       [32];
  logic [7:0] model_ram [32];
  int checks = 0, errors = 0, seen = 0, pushed = 0, last_wait = -1;

  // RAM with registered read port
  always @(posedge clock) dataRead <= ram[lcdPosRead];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected low time before a byte: previous byte's wait plus setup, plus 2 fetch cycles for chars.
  task automatic push_byte(input logic [7:0] d, input logic rs, input logic done, input int pos);
    exp_t e;
    e.data = d; e.rs = rs; e.done = done; e.pos = pos;
    e.gap  = (last_wait < 0) ? INIT_WAIT + 1 : last_wait + (rs ? 3 : 1);
    e.wt   = (!rs && d == 8'h01) ? CLEAR_WAIT : CMD_WAIT;
    last_wait = e.wt;
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic push_init();
    push_byte(8'h38, 1'b0, 1'b0, 0);
    push_byte(DISP_CTRL, 1'b0, 1'b0, 0);
    push_byte(8'h01, 1'b0, 1'b0, 0);
    push_byte(8'h06, 1'b0, 1'b0, 0);
  endtask

  task automatic push_frame();
    push_byte(8'h80, 1'b0, 1'b1, 0);
    for (int p = 0; p < 16; p++) push_byte(model_ram[p], 1'b1, 1'b1, p);
    push_byte(8'hC0, 1'b0, 1'b1, 16);
    for (int p = 16; p < 32; p++) push_byte(model_ram[p], 1'b1, 1'b1, p);
  endtask

  task automatic sched_write(input int trig, input int p, input logic [7:0] v);
    wr_t w;
    w.trig = trig; w.pos = p; w.val = v;
    wr_q.push_back(w);
    model_ram[p] = v;
  endtask

  task automatic wait_seen(input int n, input string what);
    int k = 0;
    while (seen < n && k < 3000) begin
      @(posedge clock); #1;
      k++;
    end
    chk(what, (seen >= n) ? 1 : 0, 1);
  endtask

  // Monitor: one scoreboard pop per lcd_en rising edge, plus pulse-width, gap and stability checks.
  int         low_cnt = 0, high_cnt = 0, cur_wait = 0;
  logic       prev_en = 1'b0, have_cur = 1'b0, stab_ok = 1'b1;
  logic [7:0] cur_data = 8'h00;
  logic       cur_rs = 1'b0;
  exp_t       me;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        low_cnt = 0; high_cnt = 0; have_cur = 1'b0; prev_en = 1'b0;
      end else begin
        if (lcd_en && !prev_en) begin
          if (have_cur) chk("stable", stab_ok, 1);
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", lcd_data, -1);
            have_cur = 1'b0;
          end else begin
            me = exp_q.pop_front();
            seen++;
            chk("data", lcd_data, me.data);
            chk("rs", lcd_rs, me.rs);
            chk("gap", low_cnt, me.gap);
            chk("init_done", init_done, me.done);
            chk("rw_on", {lcd_rw, lcd_on}, 2'b01);
            if (me.rs) chk("pos", lcdPosRead, me.pos);
            cur_data = me.data; cur_rs = me.rs; cur_wait = me.wt;
            have_cur = 1'b1;
          end
          stab_ok  = 1'b1;
          high_cnt = 1;
          low_cnt  = 0;
        end else if (lcd_en) begin
          high_cnt++;
          if (have_cur && (lcd_data != cur_data || lcd_rs != cur_rs)) stab_ok = 1'b0;
        end else begin
          if (prev_en) chk("en_width", high_cnt, EN_CYCLES);
          low_cnt++;
          if (have_cur && low_cnt <= cur_wait && (lcd_data != cur_data || lcd_rs != cur_rs))
            stab_ok = 1'b0;
        end
        prev_en = lcd_en;
      end
    end
  end

  initial begin
    int     nw, f1, f2, k;
    logic   hit;
    wr_t    w;

    for (int p = 0; p < 32; p++) begin
      ram[p]       = 8'(8'h41 + p);
      model_ram[p] = 8'(8'h41 + p);
    end

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_pos", lcdPosRead, 0);
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_en", lcd_en, 0);
    chk("rst_on", lcd_on, 1);
    chk("rst_init_done", init_done, 0);

    // Frame 0 uses the 'A'+pos preload; frames 1 and 2 see random rewrites plus a mid-frame write.
    push_init();
    push_frame();
    f1 = pushed;
    nw = $urandom_range(2, 4);
    for (int i = 0; i < nw; i++) sched_write(f1, $urandom_range(0, 31), 8'($urandom));
    sched_write(f1 + 3, 5, 8'h5A);
    push_frame();
    f2 = pushed;
    nw = $urandom_range(2, 5);
    for (int i = 0; i < nw; i++) sched_write(f2, $urandom_range(0, 31), 8'($urandom));
    push_frame();

    @(posedge clock); #1;
    reset = 1'b0;

    while (wr_q.size() != 0) begin
      w = wr_q.pop_front();
      wait_seen(w.trig + 1, "wait_write_trigger");
      ram[w.pos] = w.val;
    end

    // Reset for one edge while lcd_en is high during a character.
    wait_seen(f2 + 8, "wait_reset_point");
    hit = 1'b0;
    k   = 0;
    while (!hit && k < 500) begin
      if (lcd_en && lcd_rs) hit = 1'b1;
      else begin
        @(posedge clock); #1;
        k++;
      end
    end
    chk("reset_hit_en_high", hit, 1);
    reset = 1'b1;
    exp_q.delete();
    last_wait = -1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_en", lcd_en, 0);
    chk("mid_rst_init_done", init_done, 0);
    chk("mid_rst_data", lcd_data, 8'h00);
    push_init();
    push_frame();

    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge clock); #1;
      k++;
    end
    repeat (4) @(posedge clock);
    chk("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
